// File: rtl/fp_norm_round.sv
// Normalizes a raw 26-bit adder sum and rounds it to an IEEE754 single-precision result. Rounding mode is set by FP_ROUND_RNE_EN: defined gives round-to-nearest-even, undefined truncates.
// Latency from the accept edge to out_valid: 3 cycles, plus 1 per left shift. A NaN/Inf input (in_exp == FF) takes 1 cycle and a zero sum takes 2.
// Only one operation is in flight at a time: in_ready is high only in IDLE, and the result is held until out_ready.
module fp_norm_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [25:0] in_mant,
    input  logic        in_sticky,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_inexact
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NORM  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [25:0]       r_mant;
    logic signed [9:0] r_exp;
    logic              r_sign;
    logic              r_sticky;
    logic [31:0]       r_result;
    logic              r_ovf;
    logic              r_unf;
    logic              r_inx;

    logic              w_inc;
    logic [24:0]       w_sum;
    logic [22:0]       w_frac;
    logic signed [9:0] w_exp_rnd;
    logic              w_ovf;

`ifdef FP_ROUND_RNE_EN
    assign w_inc = r_mant[0] & (r_sticky | r_mant[1]);
`else
    assign w_inc = 1'b0;
`endif

    // A carry out of the 24-bit significand renormalizes by one position.
    assign w_sum     = {1'b0, r_mant[24:1]} + {24'd0, w_inc};
    assign w_frac    = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
    assign w_exp_rnd = w_sum[24] ? (r_exp + 10'sd1) : r_exp;
    assign w_ovf     = (w_exp_rnd >= 10'sd255);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mant   <= 26'd0;
            r_exp    <= 10'sd0;
            r_sign   <= 1'b0;
            r_sticky <= 1'b0;
            r_result <= 32'd0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inx    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mant   <= in_mant;
                        r_exp    <= $signed({2'b00, in_exp});
                        r_sign   <= in_sign;
                        r_sticky <= in_sticky;
                        if (in_exp == 8'hFF) begin
                            r_result <= {in_sign, 8'hFF, in_mant[23:1]};
                            r_ovf    <= 1'b0;
                            r_unf    <= 1'b0;
                            r_inx    <= 1'b0;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    if (r_mant == 26'd0) begin
                        r_result <= {r_sign, 31'd0};
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b0;
                        r_inx    <= r_sticky;
                        r_state  <= S_DONE;
                    end else if (r_mant[25]) begin
                        r_mant   <= {1'b0, r_mant[25:1]};
                        r_sticky <= r_sticky | r_mant[0];
                        r_exp    <= r_exp + 10'sd1;
                        r_state  <= S_ROUND;
                    end else if (r_mant[24]) begin
                        r_state  <= S_ROUND;
                    end else if (r_exp <= 10'sd1) begin
                        // Flush to zero rather than produce a denormal.
                        r_result <= {r_sign, 31'd0};
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b1;
                        r_inx    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_mant   <= {r_mant[24:0], 1'b0};
                        r_exp    <= r_exp - 10'sd1;
                    end
                end
                S_ROUND: begin
                    r_unf <= 1'b0;
                    if (w_ovf) begin
                        r_result <= {r_sign, 8'hFF, 23'd0};
                        r_ovf    <= 1'b1;
                        r_inx    <= 1'b1;
                    end else begin
                        r_result <= {r_sign, w_exp_rnd[7:0], w_frac};
                        r_ovf    <= 1'b0;
                        r_inx    <= r_mant[0] | r_sticky;
                    end
                    r_state <= S_DONE;
                end
                default: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready      = (r_state == S_IDLE);
    assign out_valid     = (r_state == S_DONE);
    assign out_result    = r_result;
    assign out_overflow  = r_ovf;
    assign out_underflow = r_unf;
    assign out_inexact   = r_inx;

endmodule
